// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, glyphs and FSM encoding for the 7-segment scan driver
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational nibble to active-low segment decoder
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed 7-segment driver advanced by an external slow scan clock
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_en,
    output logic [3:0]  anodes_n,
    output logic [6:0]  segments_n,
    output logic        dp_n,
    output logic [1:0]  digit_idx
);

    localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_tick;

    logic [15:0] r_digits;
    logic [3:0]  r_dp;
    logic [3:0]  r_blank;
    logic        r_lz;

    state_t      r_state;
    logic [7:0]  r_blank_cnt;
    logic [1:0]  r_idx;
    logic        r_armed;
    logic [3:0]  r_anodes_n;
    logic [6:0]  r_segments_n;
    logic        r_dp_n;

    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;
    logic [15:0] w_upper;
    logic        w_suppress;
    logic [6:0]  w_seg;
    logic        w_dp_n;
    logic [3:0]  w_anode_on;

    // scan_clk is treated as data: synchronise, then flag its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], scan_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_tick <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_lz     <= 1'b0;
        end else if (load) begin
            r_digits <= digits_in;
            r_dp     <= dp_in;
            r_blank  <= blank_in;
            r_lz     <= lz_en;
        end
    end

    assign w_nibble   = r_digits[{r_idx, 2'b00} +: 4];
    assign w_upper    = r_digits >> {r_idx, 2'b00};
    assign w_suppress = r_lz && (r_idx != 2'd0) && (w_upper == 16'd0);
    assign w_seg      = (r_blank[r_idx] || w_suppress) ? SEG_BLANK : w_glyph;
    assign w_dp_n     = r_blank[r_idx] ? 1'b1 : ~r_dp[r_idx];
    assign w_anode_on = ~(4'b0001 << r_idx);

    hex_to_7seg u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Nothing is shown after reset until the first scan tick arms the scanner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BLANK;
            r_blank_cnt  <= 8'd0;
            r_idx        <= 2'd0;
            r_armed      <= 1'b0;
            r_anodes_n   <= 4'b1111;
            r_segments_n <= SEG_BLANK;
            r_dp_n       <= 1'b1;
        end else if (r_tick) begin
            r_state      <= BLANK;
            r_blank_cnt  <= 8'd0;
            r_idx        <= r_idx + 2'd1;
            r_armed      <= 1'b1;
            r_anodes_n   <= 4'b1111;
            r_segments_n <= SEG_BLANK;
            r_dp_n       <= 1'b1;
        end else begin
            case (r_state)
                BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        if (r_armed) begin
                            r_state      <= SHOW;
                            r_anodes_n   <= w_anode_on;
                            r_segments_n <= w_seg;
                            r_dp_n       <= w_dp_n;
                        end
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 8'd1;
                    end
                end
                SHOW: begin
                    r_anodes_n   <= w_anode_on;
                    r_segments_n <= w_seg;
                    r_dp_n       <= w_dp_n;
                end
                default: begin
                    r_state    <= BLANK;
                    r_anodes_n <= 4'b1111;
                end
            endcase
        end
    end

    assign anodes_n   = r_anodes_n;
    assign segments_n = r_segments_n;
    assign dp_n       = r_dp_n;
    assign digit_idx  = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int BLANK = 4;
    localparam int SYNC  = 2;
    localparam int ADV   = SYNC + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_clk = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  anodes_n;
    logic [6:0]  segments_n;
    logic        dp_n;
    logic [1:0]  digit_idx;

    seg7_scan_driver #(.BLANK_CYCLES(BLANK), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .anodes_n   (anodes_n),
        .segments_n (segments_n),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;
    logic        m_lz = 1'b0;
    int          m_idx = 0;
    bit          m_on = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib(int k);
        logic [15:0] d;
        d = m_digits;
        return d[k*4 +: 4];
    endfunction

    function automatic logic [6:0] ref_seg(int k);
        bit all_zero;
        if (m_blank[k]) return 7'b1111111;
        all_zero = 1'b1;
        for (int j = k; j < 4; j++)
            if (nib(j) != 4'h0) all_zero = 1'b0;
        if (m_lz && k > 0 && all_zero) return 7'b1111111;
        return glyph[nib(k)];
    endfunction

    function automatic logic ref_dp(int k);
        if (m_blank[k]) return 1'b1;
        return ~m_dp[k];
    endfunction

    task automatic check_out(input string tag, input bit on, input int idx);
        logic [3:0] exp_an;
        for (int j = 0; j < 4; j++) exp_an[j] = !(on && j == idx);
        check({tag, ".anodes"}, 16'(anodes_n), 16'(exp_an));
        check({tag, ".seg"}, 16'(segments_n), 16'(on ? ref_seg(idx) : 7'b1111111));
        check({tag, ".dp"}, 16'(dp_n), 16'(on ? ref_dp(idx) : 1'b1));
        check({tag, ".idx"}, 16'(digit_idx), 16'(idx));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        lz_en     = lz;
        load      = 1'b1;
        tick_clk();
        check_out("load_old", m_on, m_idx);
        m_digits = d;
        m_dp     = dp;
        m_blank  = bl;
        m_lz     = lz;
        load     = 1'b0;
        tick_clk();
        check_out("load_new", m_on, m_idx);
    endtask

    // One scan_clk rise (or two rises two clocks apart when dbl is set)
    task automatic do_step(input bit dbl);
        int last;
        int old;
        int idx;
        bit on;
        last = dbl ? ADV + 2 : ADV;
        old  = m_idx;
        scan_clk = 1'b1;
        for (int k = 1; k <= last + BLANK + 2; k++) begin
            tick_clk();
            if (dbl && k == 1) scan_clk = 1'b0;
            if (dbl && k == 2) scan_clk = 1'b1;
            if (k == 5) scan_clk = 1'b0;
            idx = (old + (k >= ADV ? 1 : 0) + ((dbl && k >= ADV + 2) ? 1 : 0)) % 4;
            on  = (k < ADV) ? m_on : (k >= last + BLANK);
            check_out(dbl ? "step2" : "step", on, idx);
        end
        m_idx = (old + 1 + (dbl ? 1 : 0)) % 4;
        m_on  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scan_clk = ~scan_clk;
            tick_clk();
            check_out("reset", 1'b0, 0);
        end
        scan_clk = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick_clk();
            check_out("idle", 1'b0, 0);
        end

        do_load(16'h12AF, 4'b0100, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) do_step(1'b0);

        do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) do_step(1'b0);
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) do_step(1'b0);

        do_load(16'h8888, 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) do_step(1'b0);

        do_step(1'b1);

        for (int i = 0; i < 24; i++) begin
            do_load($urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                    1'($urandom_range(0, 1)));
            do_step($urandom_range(0, 4) == 0);
        end

        for (int i = 0; i < 4 && m_idx != 2; i++) do_step(1'b0);
        check("mid.on_digit2", 16'(m_idx), 16'd2);
        do_load(16'h3C00 | 16'($urandom_range(0, 255)), 4'b0100, 4'b0000, 1'b0);
        rst = 1'b1;
        m_digits = '0;
        m_dp     = '0;
        m_blank  = '0;
        m_lz     = 1'b0;
        m_idx    = 0;
        m_on     = 1'b0;
        tick_clk();
        check_out("rst_mid", 1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            check_out("post_rst", 1'b0, 0);
        end
        do_step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
